reg_file_rd_port: RTL and testbench

- Register bank of DEPTH words of WIDTH bits.
- Write side uses the same load-style interface as the single register: val/load, plus an address.
- Read side is a handshaked reader: request/grant in, valid/ready out, with a registered response that holds stable until consumed.
- Sits between datapath producers that load words and consumers (ALU/bus/debug) that read them back at their own pace.

---
 rtl/reg_file_rd_port.sv | 110 +++++++++++
 tb/tb_reg_file_rd_port.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/reg_file_rd_port.sv
// rtl/reg_file_rd_port.sv - register bank with load-style write port and handshaked registered read port
// Optional build macro: REG_FILE_WRITE_FWD_EN (same-edge write-to-read forwarding)
module reg_file_rd_port #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] val,
    input  logic             load,
    input  logic [AW-1:0]    wr_addr,
    input  logic             rd_req,
    input  logic [AW-1:0]    rd_addr,
    output logic             rd_gnt,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] out
);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    localparam int          LP_DEPTH_I = DEPTH;
    localparam logic [AW:0] LP_DEPTH   = LP_DEPTH_I[AW:0];

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_out;
    logic             w_accept;
    logic             w_wr_in_range;
    logic             w_rd_in_range;
    logic [WIDTH-1:0] w_rd_data;

    assign w_wr_in_range = ({1'b0, wr_addr} < LP_DEPTH);
    assign w_rd_in_range = ({1'b0, rd_addr} < LP_DEPTH);

    // The grant depends only on state and rd_ready so a requester never sees a loop through rd_req.
    assign rd_gnt   = (r_state == IDLE) | rd_ready;
    assign rd_valid = (r_state == RESP);
    assign w_accept = rd_req & rd_gnt;
    assign out      = r_out;

    // Read data selection: out-of-range reads return zero; optional forwarding of a same-edge write.
    always_comb begin
        w_rd_data = '0;
        if (w_rd_in_range) begin
`ifdef REG_FILE_WRITE_FWD_EN
            if (load && w_wr_in_range && (wr_addr == rd_addr)) begin
                w_rd_data = val;
            end else begin
                w_rd_data = r_mem[rd_addr];
            end
`else
            w_rd_data = r_mem[rd_addr];
`endif
        end
    end

    // Next-state logic for the read handshake FSM.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (rd_req) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                if (rd_ready) begin
                    w_state_nxt = rd_req ? RESP : IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register; reset drops any pending response at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Response register: captured only when a request is accepted, otherwise held (never cleared).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= '0;
        end else if (w_accept) begin
            r_out <= w_rd_data;
        end
    end

    // Write port: independent of the read FSM; out-of-range addresses are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (load && w_wr_in_range) begin
            r_mem[wr_addr] <= val;
        end
    end

endmodule

// File: tb/tb_reg_file_rd_port.sv
// tb/tb_reg_file_rd_port.sv - scoreboard bench for reg_file_rd_port (DEPTH=8 and DEPTH=6 instances)
module tb_reg_file_rd_port;

    logic        clk;
    logic        rst_n;
    logic [15:0] val;
    logic        load;
    logic [2:0]  wr_addr;
    logic        rd_req;
    logic [2:0]  rd_addr;
    logic        rd_ready;

    logic        rd_gnt8, rd_valid8;
    logic [15:0] out8;
    logic        rd_gnt6, rd_valid6;
    logic [15:0] out6;

    int checks;
    int errors;

    logic [15:0] m8 [8];
    logic [15:0] m6 [8];
    logic        m_resp;
    logic [15:0] q8 [$];
    logic [15:0] q6 [$];

    logic        have_cur;
    logic [15:0] cur8, cur6;

    reg_file_rd_port #(.WIDTH(16), .DEPTH(8), .AW(3)) u_dut (
        .clk(clk), .rst_n(rst_n), .val(val), .load(load), .wr_addr(wr_addr),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt8), .rd_valid(rd_valid8),
        .rd_ready(rd_ready), .out(out8)
    );

    reg_file_rd_port #(.WIDTH(16), .DEPTH(6), .AW(3)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .val(val), .load(load), .wr_addr(wr_addr),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt6), .rd_valid(rd_valid6),
        .rd_ready(rd_ready), .out(out6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m8[i] = 16'h0000;
            m6[i] = 16'h0000;
        end
        m_resp = 1'b0;
        q8.delete();
        q6.delete();
    endtask

    // One clock cycle: drive inputs just after a rising edge, check handshake outputs on the falling edge,
    // advance the reference model, then move to just after the next rising edge.
    task automatic cyc(input logic ld, input logic [2:0] wa, input logic [15:0] v,
                       input logic rq, input logic [2:0] ra, input logic rr);
        logic        exp_gnt;
        logic [15:0] e8, e6;
        load = ld; wr_addr = wa; val = v; rd_req = rq; rd_addr = ra; rd_ready = rr;
        @(negedge clk);
        exp_gnt = !m_resp || rr;
        chk("rd_gnt", {15'd0, rd_gnt8}, {15'd0, exp_gnt});
        chk("rd_gnt6", {15'd0, rd_gnt6}, {15'd0, exp_gnt});
        chk("rd_valid", {15'd0, rd_valid8}, {15'd0, m_resp});
        chk("rd_valid6", {15'd0, rd_valid6}, {15'd0, m_resp});
        if (rq && exp_gnt) begin
            e8 = m8[ra];
            e6 = (ra < 3'd6) ? m6[ra] : 16'h0000;
`ifdef REG_FILE_WRITE_FWD_EN
            if (ld && wa == ra) begin
                e8 = v;
                if (ra < 3'd6) e6 = v;
            end
`endif
            q8.push_back(e8);
            q6.push_back(e6);
        end
        if (ld) begin
            m8[wa] = v;
            if (wa < 3'd6) m6[wa] = v;
        end
        if (!m_resp) m_resp = rq;
        else if (rr) m_resp = rq;
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops one expected response per presented response and checks it every cycle it is held.
    always @(negedge clk) begin
        if (!rst_n) begin
            have_cur = 1'b0;
        end else if (rd_valid8) begin
            if (!have_cur) begin
                checks++;
                if (q8.size() == 0 || q6.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_response got rd_valid=1 expected no response at %0t", $time);
                end else begin
                    cur8 = q8.pop_front();
                    cur6 = q6.pop_front();
                    have_cur = 1'b1;
                end
            end
            if (have_cur) begin
                chk("out", out8, cur8);
                chk("out6", out6, cur6);
                if (rd_ready) have_cur = 1'b0;
            end
        end
    end

    initial begin
        checks = 0; errors = 0; have_cur = 1'b0;
        rst_n = 1'b0; load = 1'b0; wr_addr = '0; val = '0; rd_req = 1'b0; rd_addr = '0; rd_ready = 1'b0;
        model_reset();
        #2;
        chk("rst_out", out8, 16'h0000);
        chk("rst_valid", {15'd0, rd_valid8}, 16'h0000);
        chk("rst_gnt", {15'd0, rd_gnt8}, 16'h0001);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Reset in the middle of a held response.
        cyc(1, 3'd5, 16'h5A5A, 0, 3'd0, 1);
        cyc(0, 3'd0, 16'h0000, 1, 3'd5, 0);
        cyc(0, 3'd0, 16'h0000, 0, 3'd0, 0);
        chk("pre_rst_valid", {15'd0, rd_valid8}, 16'h0001);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out", out8, 16'h0000);
        chk("mid_rst_out6", out6, 16'h0000);
        chk("mid_rst_valid", {15'd0, rd_valid8}, 16'h0000);
        chk("mid_rst_gnt", {15'd0, rd_gnt8}, 16'h0001);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(0, 3'd0, 16'h0000, 1, 3'd5, 1);
        cyc(0, 3'd0, 16'h0000, 0, 3'd0, 1);

        // Write then read, then hold under backpressure while the word is rewritten.
        cyc(1, 3'd3, 16'h0003, 0, 3'd0, 1);
        cyc(0, 3'd0, 16'h0000, 1, 3'd3, 1);
        cyc(1, 3'd3, 16'h000F, 0, 3'd0, 0);
        cyc(1, 3'd3, 16'h000F, 0, 3'd0, 0);
        cyc(1, 3'd3, 16'h000F, 0, 3'd0, 0);
        cyc(1, 3'd3, 16'h000F, 1, 3'd5, 0);
        cyc(0, 3'd0, 16'h0000, 0, 3'd0, 1);
        cyc(0, 3'd0, 16'h0000, 1, 3'd3, 1);
        cyc(0, 3'd0, 16'h0000, 0, 3'd0, 1);

        // Back-to-back reads, including an address beyond the DEPTH=6 instance.
        cyc(1, 3'd1, 16'h1111, 0, 3'd0, 1);
        cyc(1, 3'd2, 16'h2222, 0, 3'd0, 1);
        cyc(1, 3'd7, 16'h7777, 0, 3'd0, 1);
        cyc(0, 3'd0, 16'h0000, 1, 3'd1, 1);
        cyc(0, 3'd0, 16'h0000, 1, 3'd2, 1);
        cyc(0, 3'd0, 16'h0000, 1, 3'd7, 1);
        cyc(0, 3'd0, 16'h0000, 0, 3'd0, 1);

        // Same-edge write and read of one address, then a plain re-read.
        cyc(1, 3'd4, 16'hAAAA, 0, 3'd0, 1);
        cyc(1, 3'd4, 16'h5555, 1, 3'd4, 1);
        cyc(0, 3'd0, 16'h0000, 1, 3'd4, 1);
        cyc(0, 3'd0, 16'h0000, 0, 3'd0, 1);

        // Out-of-range write/read on the DEPTH=6 instance, then sweep addresses 0-5.
        cyc(1, 3'd0, 16'hC0C0, 0, 3'd0, 1);
        cyc(1, 3'd6, 16'hFFFF, 0, 3'd0, 1);
        cyc(0, 3'd0, 16'h0000, 1, 3'd6, 1);
        for (int a = 0; a < 6; a++) begin
            cyc(0, 3'd0, 16'h0000, 1, 3'(a), 1);
        end
        cyc(0, 3'd0, 16'h0000, 0, 3'd0, 1);
        cyc(0, 3'd0, 16'h0000, 0, 3'd0, 1);

        chk("queue_drained", 16'(q8.size()), 16'h0000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
